// File: rtl/led_seq_pkg.sv
// Shared encodings and defaults for the LED sequencer: mode values, the
// pattern each mode starts from, and the bounce direction flag.
package led_seq_pkg;

   typedef enum logic [1:0] {
      BLINK  = 2'd0,
      RUN    = 2'd1,
      BOUNCE = 2'd2,
      COUNT  = 2'd3
   } mode_e;

   localparam int unsigned TICK_CYCLES_DEF     = 32'd12_500_000;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd1_000_000;

   localparam logic [3:0] PAT_BLINK_INIT  = 4'b0000;
   localparam logic [3:0] PAT_RUN_INIT    = 4'b0001;
   localparam logic [3:0] PAT_BOUNCE_INIT = 4'b0001;
   localparam logic [3:0] PAT_COUNT_INIT  = 4'b0000;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic logic [3:0] init_pattern(input mode_e m);
      logic [3:0] p;
      case (m)
         BLINK:   p = PAT_BLINK_INIT;
         RUN:     p = PAT_RUN_INIT;
         BOUNCE:  p = PAT_BOUNCE_INIT;
         default: p = PAT_COUNT_INIT;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Mode button front end: two-flop synchronizer, stability debounce and a
// one-cycle pulse on each accepted press (stable level falling edge).
module key_debounce
   import led_seq_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          stable_q, stable_d;
   logic          press_q, press_d;
   logic          armed_q, armed_d;
   logic [1:0]    fill_q;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      press_d  = 1'b0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            press_d  = ~sync2_q & armed_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      // A press only counts once the key has been seen released after reset;
      // fill_q marks when sync2_q first carries a real sample of the pin.
      armed_d = armed_q | (fill_q[1] & sync2_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
         armed_q  <= 1'b0;
         fill_q   <= 2'b00;
      end else begin
         sync1_q  <= key_n;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
         armed_q  <= armed_d;
         fill_q   <= {fill_q[0], 1'b1};
      end
   end

   assign key_press = press_q;

endmodule

// File: rtl/led_sequencer.sv
// Four-LED pattern sequencer: a button cycles through four display modes and
// a programmable tick steps the current mode's pattern.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter int unsigned TICK_CYCLES     = TICK_CYCLES_DEF,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   input  logic [1:0] speed_sel,
   output logic [3:0] led,
   output logic [1:0] mode
);

   logic        key_press;
   mode_e       mode_q, mode_d;
   logic [3:0]  led_q, led_d, step_pat;
   logic        dir_q, dir_d, step_dir;
   logic [31:0] tick_cnt_q, tick_cnt_d;
   logic [32:0] period;
   logic        tick;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk      (clk),
      .rst      (rst),
      .key_n    (key_n),
      .key_press(key_press)
   );

   // Compare count+1 against the period so a zero period never wraps.
   assign period = {1'b0, 32'(TICK_CYCLES) >> speed_sel};
   assign tick   = ({1'b0, tick_cnt_q} + 33'd1) >= period;

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= BLINK;
      end else begin
         mode_q <= mode_d;
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (key_press) begin
         mode_d = mode_e'(2'(mode_q + 2'd1));
      end
   end

   always_comb begin
      mode = mode_q;
   end

   always_comb begin
      step_pat = led_q;
      step_dir = dir_q;
      case (mode_q)
         BLINK: step_pat = ~led_q;
         RUN:   step_pat = {led_q[2:0], led_q[3]};
         BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
               if (led_q == 4'b1000) begin
                  step_pat = 4'b0100;
                  step_dir = DIR_RIGHT;
               end else begin
                  step_pat = led_q << 1;
               end
            end else begin
               if (led_q == 4'b0001) begin
                  step_pat = 4'b0010;
                  step_dir = DIR_LEFT;
               end else begin
                  step_pat = led_q >> 1;
               end
            end
         end
         default: step_pat = led_q + 4'd1;
      endcase
   end

   // A mode change overrides any coincident tick.
   always_comb begin
      led_d      = led_q;
      dir_d      = dir_q;
      tick_cnt_d = tick_cnt_q + 32'd1;
      if (key_press) begin
         led_d      = init_pattern(mode_d);
         dir_d      = DIR_LEFT;
         tick_cnt_d = '0;
      end else if (tick) begin
         led_d      = step_pat;
         dir_d      = step_dir;
         tick_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q      <= PAT_BLINK_INIT;
         dir_q      <= DIR_LEFT;
         tick_cnt_q <= '0;
      end else begin
         led_q      <= led_d;
         dir_q      <= dir_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign led = led_q;

endmodule
